// File: rtl/canon_player_pkg.sv
// Shared definitions for the canon player: note codes, the 12 MHz half-period
// table, the song ROM, beat-time constants, FSM state and per-voice state.
// No ports (package). Imported by canon_tone_gen and canon_player.
package canon_player_pkg;

    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned TONE_W     = 16;
    localparam int unsigned CLK_HZ     = 12_000_000;
    localparam int unsigned BEAT_TICKS = CLK_HZ / 2;   // 500 ms beat

    typedef enum logic [3:0] {
        REST = 4'd0,
        DO   = 4'd1,
        RE   = 4'd2,
        MI   = 4'd3,
        FA   = 4'd4,
        SOL  = 4'd5,
        LA   = 4'd6,
        SI   = 4'd7,
        DO2  = 4'd8
    } note_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    typedef struct packed {
        logic              active;
        logic              finished;
        logic [ADDR_W-1:0] addr;
    } voice_t;

    // Half-period in clk cycles at 12 MHz (clk / (2 * f)).
    function automatic logic [TONE_W-1:0] note_half(input note_e code);
        logic [TONE_W-1:0] h;
        h = '0;
        case (code)
            DO:      h = 16'd22934;
            RE:      h = 16'd20431;
            MI:      h = 16'd18202;
            FA:      h = 16'd17181;
            SOL:     h = 16'd15306;
            LA:      h = 16'd13636;
            SI:      h = 16'd12149;
            DO2:     h = 16'd11467;
            default: h = '0;
        endcase
        return h;
    endfunction

    // Scaled half-period; never 0 so the tone counter always has a terminal count.
    function automatic logic [TONE_W-1:0] tone_half(input note_e code, input int unsigned shift);
        logic [TONE_W-1:0] h;
        h = note_half(code) >> shift;
        if (h == '0) begin
            h = TONE_W'(1);
        end
        return h;
    endfunction

    // Frere Jacques, 40 entries; everything past the song reads as a rest.
    function automatic note_e song_note(input logic [ADDR_W-1:0] idx);
        note_e n;
        n = REST;
        case (idx)
            6'd0, 6'd3, 6'd4, 6'd7, 6'd21, 6'd27,
            6'd28, 6'd30, 6'd32, 6'd34:                 n = DO;
            6'd1, 6'd5:                                 n = RE;
            6'd2, 6'd6, 6'd8, 6'd12, 6'd20, 6'd26:      n = MI;
            6'd9, 6'd13, 6'd19, 6'd25:                  n = FA;
            6'd10, 6'd14, 6'd16, 6'd18, 6'd22, 6'd24,
            6'd29, 6'd33:                               n = SOL;
            6'd17, 6'd23:                               n = LA;
            default:                                    n = REST;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/canon_tone_gen.sv
// Square-wave tone generator for one voice.
// Ports: clk, rst (sync, active-high); half = half-period in cycles (>= 1);
// mute = force tone low and hold the counter; restart = clear counter and tone;
// tone = registered square-wave output.
module canon_tone_gen
    import canon_player_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TONE_W-1:0] half,
    input  logic              mute,
    input  logic              restart,
    output logic              tone
);

    logic [TONE_W-1:0] cnt_q, cnt_d;
    logic              tone_q, tone_d;

    // Restart beats mute; mute freezes the counter in place.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (restart) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (mute) begin
            tone_d = 1'b0;
        end else if (cnt_q >= half - TONE_W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end else begin
            cnt_d = cnt_q + TONE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/canon_player.sv
// Multi-voice round player: one song ROM shared by VOICES voices, voice v
// entering VOICE_LAG beats after voice v-1, each voice with its own tone gen.
// Ports: clk, rst (sync, active-high); start/stop/loop control levels;
// ch_out[v] tone per voice; voice_active[v]; busy (in PLAY); beat (one-cycle
// strobe at each beat boundary); done (one-cycle strobe at one-shot end).
// Build option: define CANON_PLAYER_ARTIC_EN to silence the last 1/8 of each
// beat (detached notes); undefined gives legato.
module canon_player
    import canon_player_pkg::*;
#(
    parameter int unsigned VOICES      = 2,
    parameter int unsigned SONG_LEN    = 40,
    parameter int unsigned VOICE_LAG   = 20,
    parameter int unsigned TEMPO_TICKS = BEAT_TICKS,
    parameter int unsigned DIV_SHIFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [VOICES-1:0] ch_out,
    output logic [VOICES-1:0] voice_active,
    output logic              busy,
    output logic              beat,
    output logic              done
);

    localparam int unsigned TW     = (TEMPO_TICKS > 1) ? $clog2(TEMPO_TICKS) : 1;
    localparam int unsigned BC_MAX = (VOICES - 1) * VOICE_LAG;
    localparam int unsigned BC_W   = (BC_MAX > 0) ? $clog2(BC_MAX + 1) : 1;

    localparam logic [TW-1:0]     TEMPO_LAST = TW'(TEMPO_TICKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SONG_LEN - 1);
    localparam logic [BC_W-1:0]   BC_TOP     = BC_W'(BC_MAX);

    state_e            state_q, state_d;
    logic [TW-1:0]     tempo_q, tempo_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    voice_t            voice_q [VOICES];
    voice_t            voice_d [VOICES];
    logic              busy_q, busy_d;
    logic              beat_q, beat_d;
    logic              done_q, done_d;
    logic [VOICES-1:0] note_chg;
    logic              beat_tick;
    logic              fin_all;
    logic              artic_mute;

    // Next-state: tempo/beat counters, voice entry/advance/finish, FSM.
    always_comb begin
        state_d   = state_q;
        tempo_d   = tempo_q;
        bc_d      = bc_q;
        voice_d   = voice_q;
        note_chg  = '0;
        done_d    = 1'b0;
        fin_all   = 1'b0;
        beat_tick = (state_q == ST_PLAY) && (tempo_q == TEMPO_LAST);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_PLAY;
                    tempo_d = '0;
                    bc_d    = '0;
                    for (int v = 0; v < VOICES; v++) begin
                        voice_d[v] = '0;
                    end
                    voice_d[0].active = 1'b1;
                    note_chg[0]       = 1'b1;
                end
            end
            ST_PLAY: begin
                tempo_d = beat_tick ? '0 : tempo_q + TW'(1);
                if (beat_tick && bc_q != BC_TOP) begin
                    bc_d = bc_q + BC_W'(1);
                end
                for (int v = 0; v < VOICES; v++) begin
                    if (beat_tick) begin
                        if (voice_q[v].active) begin
                            note_chg[v] = 1'b1;
                            if (voice_q[v].addr == ADDR_LAST) begin
                                voice_d[v].addr = '0;
                                if (!loop) begin
                                    voice_d[v].active   = 1'b0;
                                    voice_d[v].finished = 1'b1;
                                end
                            end else begin
                                voice_d[v].addr = voice_q[v].addr + ADDR_W'(1);
                            end
                        end else if (!voice_q[v].finished && bc_d != bc_q &&
                                     bc_d == BC_W'(v * VOICE_LAG)) begin
                            // Entry only on the beat the counter steps onto this voice's slot.
                            voice_d[v].active = 1'b1;
                            voice_d[v].addr   = '0;
                            note_chg[v]       = 1'b1;
                        end
                    end
                end
                fin_all = 1'b1;
                for (int v = 0; v < VOICES; v++) begin
                    fin_all = fin_all & voice_d[v].finished;
                end
                if (fin_all || stop) begin
                    state_d = ST_IDLE;
                    done_d  = fin_all && !stop;
                    tempo_d = '0;
                    bc_d    = '0;
                    for (int v = 0; v < VOICES; v++) begin
                        voice_d[v] = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_PLAY);
        beat_d = (state_d == ST_PLAY) && (tempo_d == TEMPO_LAST);
    end

`ifdef CANON_PLAYER_ARTIC_EN
    localparam bit            ARTIC_ON    = (TEMPO_TICKS / 8) > 0;
    localparam logic [TW-1:0] ARTIC_START = TW'(TEMPO_TICKS - TEMPO_TICKS / 8);

    // Silence the tail of every beat so repeated notes are separated.
    always_comb begin
        artic_mute = ARTIC_ON && (tempo_d >= ARTIC_START);
    end
`else
    always_comb begin
        artic_mute = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tempo_q <= '0;
            bc_q    <= '0;
            busy_q  <= 1'b0;
            beat_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                voice_q[v] <= '0;
            end
        end else begin
            state_q <= state_d;
            tempo_q <= tempo_d;
            bc_q    <= bc_d;
            busy_q  <= busy_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            for (int v = 0; v < VOICES; v++) begin
                voice_q[v] <= voice_d[v];
            end
        end
    end

    // Tone gens are fed next-state values so ch_out lines up with addr/active.
    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        note_e             code_c;
        logic [TONE_W-1:0] half_c;
        logic              mute_c;
        logic              restart_c;

        assign code_c    = song_note(voice_d[g].addr);
        assign half_c    = tone_half(code_c, DIV_SHIFT);
        assign mute_c    = (code_c == REST) || artic_mute;
        assign restart_c = note_chg[g] || !voice_d[g].active;

        canon_tone_gen u_tone (
            .clk     (clk),
            .rst     (rst),
            .half    (half_c),
            .mute    (mute_c),
            .restart (restart_c),
            .tone    (ch_out[g])
        );

        assign voice_active[g] = voice_q[g].active;
    end

    assign busy = busy_q;
    assign beat = beat_q;
    assign done = done_q;

endmodule
